// File: rtl/ex_wb_writeback.sv
// EX/WB pipeline register, 8-entry register file with write-through read ports.
// Optional retired-write counter is built when EX_WB_RETIRE_CNT_EN is defined.
module ex_wb_writeback #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 3,
  parameter int RC_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              EX_Valid,
  input  logic              EX_RegWrite,
  input  logic              EX_SMCtrl,
  input  logic [REG_N-1:0]  EX_Write_Reg_Num,
  input  logic [DATA_W-1:0] EX_Data1,
  input  logic [DATA_W-1:0] EX_Shift_Result,
  input  logic [REG_N-1:0]  Read_Reg_Num1,
  input  logic [REG_N-1:0]  Read_Reg_Num2,
  output logic [DATA_W-1:0] Read_Data1,
  output logic [DATA_W-1:0] Read_Data2,
  output logic              EX_WB_Valid,
  output logic              EX_WB_RegWrite,
  output logic              EX_WB_SMCtrl,
  output logic [REG_N-1:0]  EX_WB_Write_Reg_Num,
  output logic [DATA_W-1:0] EX_WB_Data1,
  output logic [DATA_W-1:0] EX_WB_Shift_Result,
  output logic              EX_WB_Fwd_Valid,
  output logic [RC_W-1:0]   Retire_Count
);

  localparam int NREG = 1 << REG_N;

  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] wb_data;
  logic              retire;

  assign wb_data         = EX_WB_SMCtrl ? EX_WB_Data1 : EX_WB_Shift_Result;
  assign EX_WB_Fwd_Valid = EX_WB_Valid & EX_WB_RegWrite;
  // A held entry still retires on a flush edge before the bubble replaces it.
  assign retire          = EX_WB_Fwd_Valid & (~stall | flush);

  // EX -> WB boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EX_WB_Valid         <= 1'b0;
      EX_WB_RegWrite      <= 1'b0;
      EX_WB_SMCtrl        <= 1'b0;
      EX_WB_Write_Reg_Num <= '0;
      EX_WB_Data1         <= '0;
      EX_WB_Shift_Result  <= '0;
    end else if (flush) begin
      EX_WB_Valid         <= 1'b0;
      EX_WB_RegWrite      <= 1'b0;
      EX_WB_SMCtrl        <= 1'b0;
      EX_WB_Write_Reg_Num <= '0;
      EX_WB_Data1         <= '0;
      EX_WB_Shift_Result  <= '0;
    end else if (!stall) begin
      EX_WB_Valid         <= EX_Valid;
      EX_WB_RegWrite      <= EX_RegWrite;
      EX_WB_SMCtrl        <= EX_SMCtrl;
      EX_WB_Write_Reg_Num <= EX_Write_Reg_Num;
      EX_WB_Data1         <= EX_Data1;
      EX_WB_Shift_Result  <= EX_Shift_Result;
    end
  end

  // WB -> register file boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (retire) begin
      rf[EX_WB_Write_Reg_Num] <= wb_data;
    end
  end

  // Write-through lets ID see a result one cycle before it lands in rf.
  assign Read_Data1 = (EX_WB_Fwd_Valid && (Read_Reg_Num1 == EX_WB_Write_Reg_Num))
                      ? wb_data : rf[Read_Reg_Num1];
  assign Read_Data2 = (EX_WB_Fwd_Valid && (Read_Reg_Num2 == EX_WB_Write_Reg_Num))
                      ? wb_data : rf[Read_Reg_Num2];

`ifdef EX_WB_RETIRE_CNT_EN
  logic [RC_W-1:0] retire_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + RC_W'(1);
  end

  assign Retire_Count = retire_cnt;
`else
  assign Retire_Count = '0;
`endif

endmodule

// File: tb/tb_ex_wb_writeback.sv
// Directed bench for ex_wb_writeback: reset, move/shift select, stall, flush,
// non-writing entries, back-to-back writes, mid-stall reset and counter wrap.
module tb_ex_wb_writeback;

  logic       clk = 1'b0;
  logic       reset, stall, flush;
  logic       EX_Valid, EX_RegWrite, EX_SMCtrl;
  logic [2:0] EX_Write_Reg_Num;
  logic [7:0] EX_Data1, EX_Shift_Result;
  logic [2:0] Read_Reg_Num1, Read_Reg_Num2;
  logic [7:0] Read_Data1, Read_Data2;
  logic       EX_WB_Valid, EX_WB_RegWrite, EX_WB_SMCtrl, EX_WB_Fwd_Valid;
  logic [2:0] EX_WB_Write_Reg_Num;
  logic [7:0] EX_WB_Data1, EX_WB_Shift_Result;
  logic [3:0] Retire_Count;

  int checks = 0;
  int errors = 0;
  int retired = 0;

  ex_wb_writeback #(.DATA_W(8), .REG_N(3), .RC_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite), .EX_SMCtrl(EX_SMCtrl),
    .EX_Write_Reg_Num(EX_Write_Reg_Num), .EX_Data1(EX_Data1),
    .EX_Shift_Result(EX_Shift_Result),
    .Read_Reg_Num1(Read_Reg_Num1), .Read_Reg_Num2(Read_Reg_Num2),
    .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
    .EX_WB_Valid(EX_WB_Valid), .EX_WB_RegWrite(EX_WB_RegWrite),
    .EX_WB_SMCtrl(EX_WB_SMCtrl), .EX_WB_Write_Reg_Num(EX_WB_Write_Reg_Num),
    .EX_WB_Data1(EX_WB_Data1), .EX_WB_Shift_Result(EX_WB_Shift_Result),
    .EX_WB_Fwd_Valid(EX_WB_Fwd_Valid), .Retire_Count(Retire_Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic sm, input logic [2:0] num,
                       input logic [7:0] d1, input logic [7:0] sh);
    EX_Valid = v; EX_RegWrite = rw; EX_SMCtrl = sm;
    EX_Write_Reg_Num = num; EX_Data1 = d1; EX_Shift_Result = sh;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    Read_Reg_Num1 = a; Read_Reg_Num2 = b;
    #1;
  endtask

  function automatic logic [3:0] exp_cnt();
`ifdef EX_WB_RETIRE_CNT_EN
    return 4'(retired);
`else
    return 4'h0;
`endif
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    Read_Reg_Num1 = 3'd0; Read_Reg_Num2 = 3'd0;
    #12;
    chk("rst_valid", EX_WB_Valid, 0);
    chk("rst_fwd", EX_WB_Fwd_Valid, 0);
    chk("rst_cnt", Retire_Count, 0);
    reset = 1'b0;
    tick();

    // Move then shift
    drive(1, 1, 1, 3'd3, 8'hA5, 8'h3C);
    tick();
    chk("r3_valid", EX_WB_Valid, 1);
    chk("r3_fwd", EX_WB_Fwd_Valid, 1);
    chk("r3_num", EX_WB_Write_Reg_Num, 3);
    chk("r3_d1", EX_WB_Data1, 8'hA5);
    chk("r3_sh", EX_WB_Shift_Result, 8'h3C);
    rd(3'd3, 3'd4);
    chk("r3_wt", Read_Data1, 8'hA5);
    chk("r4_pre", Read_Data2, 8'h00);
    drive(1, 1, 0, 3'd4, 8'hA5, 8'h3C);
    tick(); retired++;
    rd(3'd4, 3'd3);
    chk("r4_wt", Read_Data1, 8'h3C);
    chk("r3_rf", Read_Data2, 8'hA5);
    chk("cnt_1", Retire_Count, exp_cnt());
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    tick(); retired++;
    chk("bub_fwd", EX_WB_Fwd_Valid, 0);
    rd(3'd4, 3'd4);
    chk("r4_rf_p1", Read_Data1, 8'h3C);
    chk("r4_rf_p2", Read_Data2, 8'h3C);

    // Stall holds entry; retires once when released
    drive(1, 1, 1, 3'd2, 8'h11, 8'h00);
    tick();
    stall = 1'b1;
    drive(1, 1, 1, 3'd7, 8'h55, 8'h66);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_num", EX_WB_Write_Reg_Num, 2);
      chk("stl_d1", EX_WB_Data1, 8'h11);
      rd(3'd2, 3'd7);
      chk("stl_wt", Read_Data1, 8'h11);
      chk("stl_r7", Read_Data2, 8'h00);
      chk("stl_cnt", Retire_Count, exp_cnt());
    end
    stall = 1'b0;
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    tick(); retired++;
    chk("unstl_valid", EX_WB_Valid, 0);
    rd(3'd2, 3'd2);
    chk("r2_rf", Read_Data1, 8'h11);
    chk("unstl_cnt", Retire_Count, exp_cnt());

    // Flush overrides stall: held entry retires, bubble loaded
    drive(1, 1, 1, 3'd5, 8'h77, 8'h00);
    tick();
    stall = 1'b1;
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    tick();
    chk("hold_num", EX_WB_Write_Reg_Num, 5);
    flush = 1'b1;
    drive(1, 1, 1, 3'd6, 8'h99, 8'h00);
    tick(); retired++;
    flush = 1'b0; stall = 1'b0;
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    chk("fl_valid", EX_WB_Valid, 0);
    chk("fl_rw", EX_WB_RegWrite, 0);
    chk("fl_d1", EX_WB_Data1, 8'h00);
    rd(3'd5, 3'd6);
    chk("r5_rf", Read_Data1, 8'h77);
    chk("r6_rf", Read_Data2, 8'h00);
    chk("fl_cnt", Retire_Count, exp_cnt());
    tick();

    // Non-writing entry
    drive(1, 0, 1, 3'd1, 8'hFF, 8'hFF);
    tick();
    chk("nw_valid", EX_WB_Valid, 1);
    chk("nw_fwd", EX_WB_Fwd_Valid, 0);
    rd(3'd1, 3'd1);
    chk("nw_nowt", Read_Data1, 8'h00);
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    tick();
    chk("nw_rf", Read_Data1, 8'h00);
    chk("nw_cnt", Retire_Count, exp_cnt());

    // Back-to-back writes to r7
    drive(1, 1, 1, 3'd7, 8'h12, 8'h00);
    tick();
    drive(1, 1, 0, 3'd7, 8'h00, 8'h34);
    tick(); retired++;
    rd(3'd7, 3'd7);
    chk("b2b_wt", Read_Data1, 8'h34);
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    tick(); retired++;
    chk("b2b_rf", Read_Data2, 8'h34);

    // Reset mid-stall drops the pending write
    drive(1, 1, 1, 3'd6, 8'hAB, 8'h00);
    tick();
    stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("mr_valid", EX_WB_Valid, 0);
    chk("mr_fwd", EX_WB_Fwd_Valid, 0);
    chk("mr_num", EX_WB_Write_Reg_Num, 0);
    chk("mr_cnt", Retire_Count, 0);
    for (int r = 0; r < 8; r++) begin
      rd(3'(r), 3'(7 - r));
      chk("mr_p1", Read_Data1, 8'h00);
      chk("mr_p2", Read_Data2, 8'h00);
    end
    retired = 0;
    stall = 1'b0;
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    rd(3'd6, 3'd7);
    chk("mr_r6_lost", Read_Data1, 8'h00);
    chk("mr_r7_clr", Read_Data2, 8'h00);

    // 17 retiring writes wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 1, 3'd0, 8'(i), 8'h00);
      tick();
      if (i > 0) retired++;
    end
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    tick(); retired++;
    rd(3'd0, 3'd0);
    chk("wrap_r0", Read_Data1, 8'h10);
    chk("wrap_cnt", Retire_Count, exp_cnt());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
